axi_line_reader: RTL and testbench
==================================

AXI_LINE_READER -- requirements
Module: axi_line_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning request/AXI address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, meaning refill line width in bits.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning AXI R-channel data width; beats per line NBEAT = LINE_WIDTH/AXI_DATA_WIDTH (default 4).
REQ-004 SHALL have parameter AXI_ID, default 4'h0, meaning constant ARID driven on every request.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rreq_i  input  1  line refill request from the instruction cache.
REQ-008 SHALL have port addr_i  input  ADDR_WIDTH  refill address, any byte within the line.
REQ-009 SHALL have port rdy_o  output  1  request accepted this cycle when high together with rreq_i.
REQ-010 SHALL have port rvalid_o  output  1  one-cycle pulse: rdata_o holds the complete line.
REQ-011 SHALL have port rdata_o  output  LINE_WIDTH  assembled line; beat k occupies bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
REQ-012 SHALL have port err_o  output  1  line contained an error response (see REQ-031).
REQ-013 SHALL have AXI AR-channel ports arid(4), araddr(ADDR_WIDTH), arlen(8), arsize(3), arburst(2), arvalid(1) as outputs and arready(1) as input.
REQ-014 SHALL have AXI R-channel ports rid(4), rdata(AXI_DATA_WIDTH), rresp(2), rlast(1), rvalid(1) as inputs and rready(1) as output.

Function
REQ-015 SHALL implement FSM states IDLE, AR, RDATA, DONE.
REQ-016 IDLE: rdy_o=1; on rreq_i=1, SHALL latch addr_i with the low log2(LINE_WIDTH/8) bits zeroed, clear the beat counter and the error flag, and go to AR.
REQ-017 rdy_o SHALL be 0 in AR, RDATA and DONE; a request held high during or after a refill SHALL NOT be re-accepted before DONE->IDLE.
REQ-018 AR: arvalid=1, araddr=latched aligned address, arlen=NBEAT-1, arsize=log2(AXI_DATA_WIDTH/8), arburst=2'b01 (INCR), arid=AXI_ID; on arready=1, go to RDATA.
REQ-019 arvalid SHALL be 0 outside AR, and AR outputs SHALL remain stable while arvalid=1 and arready=0.
REQ-020 RDATA: rready=1; each cycle with rvalid=1, rdata SHALL be written to line slot [counter] and the counter SHALL increment.
REQ-021 The beat with counter=NBEAT-1 SHALL complete the line and move to DONE; rlast and rid SHALL NOT affect counting.
REQ-022 rready SHALL be 0 outside RDATA.
REQ-023 DONE: rvalid_o=1 for exactly one cycle, then go to IDLE.
REQ-024 rdata_o SHALL hold the last completed line until the next line completes.
REQ-025 Minimum latency: accept at cycle T, arready at T+1, beats at T+2..T+5, rvalid_o at T+6.
REQ-026 AXI stalls (arready=0, rvalid=0 gaps) SHALL only extend latency and SHALL NOT cause beats to be lost or reordered.
REQ-027 At most one outstanding AXI transaction at a time.

Reset
REQ-028 On rst: state=IDLE; rdy_o=0 during the reset cycle; rvalid_o=0, err_o=0, arvalid=0, rready=0, counter=0, rdata_o=0.
REQ-029 rst asserted mid-transaction (AR or RDATA) SHALL abandon the transaction without producing rvalid_o; the interconnect is reset by the same rst.
REQ-030 The first request after reset release SHALL be accepted in the first cycle with rst=0.

Configuration
REQ-031 With macro AXI_RRESP_CHECK_EN defined: any accepted beat with rresp!=2'b00 SHALL set a sticky flag; err_o SHALL equal that flag while rvalid_o=1 and be 0 otherwise. The line SHALL still complete after NBEAT beats.
REQ-032 Without AXI_RRESP_CHECK_EN: err_o SHALL be tied 0 and rresp ignored.

Verification
REQ-033 Reset then rreq_i=1, addr_i=0x1C00_0014, arready=1 immediately, 4 back-to-back beats 0x11111111..0x44444444 -> araddr=0x1C00_0010, arlen=3, arsize=2, arburst=1; rvalid_o at T+6; rdata_o=0x44444444_33333333_22222222_11111111.
REQ-034 arready delayed 5 cycles; rvalid gaps of 2 cycles between beats -> AR outputs stable, same line assembled, single rvalid_o pulse.
REQ-035 rreq_i held high through the rvalid_o cycle and then dropped -> exactly one AR handshake.
REQ-036 rst pulsed after the second beat -> arvalid/rready=0 next cycle, no rvalid_o; a new request at 0x0000_0040 completes correctly.
REQ-037 With AXI_RRESP_CHECK_EN, beat 2 rresp=2'b10 -> err_o=1 with rvalid_o; next clean line err_o=0; without macro err_o=0 always.

Source files
------------

// File: rtl/axi_line_reader.sv
// axi_line_reader
//   Fetches one cache line over an AXI4 read channel. It takes a refill
//   request from the instruction cache, issues a single aligned INCR burst
//   of NBEAT = LINE_WIDTH/AXI_DATA_WIDTH beats, assembles the beats into a
//   line and presents it with a one-cycle rvalid_o pulse.
//
//   Optional feature (macro AXI_RRESP_CHECK_EN): when defined, any beat
//   with a non-OKAY rresp marks the line as erroneous and err_o is raised
//   together with rvalid_o. When undefined, err_o is constant 0.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   rreq_i, addr_i  refill request and any byte address within the line
//   rdy_o           high in IDLE (not during reset): request taken
//   rvalid_o        one-cycle pulse, rdata_o holds the complete line
//   rdata_o         last completed line, beat k at [k*AXI_DATA_WIDTH +: ..]
//   err_o           line carried an error response (valid with rvalid_o)
//   ar*             AXI read address channel (master side)
//   r*              AXI read data channel (master side)
module axi_line_reader #(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         LINE_WIDTH     = 128,
  parameter int         AXI_DATA_WIDTH = 32,
  parameter logic [3:0] AXI_ID         = 4'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rreq_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  output logic                      rdy_o,
  output logic                      rvalid_o,
  output logic [LINE_WIDTH-1:0]     rdata_o,
  output logic                      err_o,
  output logic [3:0]                arid,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int NBEAT = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

  typedef enum logic [1:0] {IDLE, AR, RDATA, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [LINE_WIDTH-1:0]   line_buf;   // beats collected so far
  logic [LINE_WIDTH-1:0]   line_next;  // line_buf with the current beat merged in
  logic [LINE_WIDTH-1:0]   line_reg;   // last completed line, shown on rdata_o
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic                    rvalid_reg;
  logic                    err_flag;
  logic                    err_reg;
  logic                    beat_err;
  logic [ADDR_WIDTH-1:0]   aligned_addr;

  // rid and rlast are deliberately ignored: beats are counted, not tagged.
  logic unused_ok;

`ifdef AXI_RRESP_CHECK_EN
  assign beat_err  = (rresp != 2'b00);
  assign unused_ok = ^{rid, rlast};
`else
  assign beat_err  = 1'b0;
  assign unused_ok = ^{rid, rlast, rresp};
`endif

  assign aligned_addr = {addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Merge the incoming beat into its slot; other slots keep collected data.
  generate
    for (genvar gi = 0; gi < NBEAT; gi++) begin : g_slot
      assign line_next[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
        (beat_cnt == CNT_W'(gi)) ? rdata
                                 : line_buf[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_reg    <= '0;
      beat_cnt    <= '0;
      line_buf    <= '0;
      line_reg    <= '0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      rvalid_reg  <= 1'b0;
      err_flag    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses.
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      case (state)
        IDLE: begin
          if (rreq_i) begin
            addr_reg    <= aligned_addr;
            beat_cnt    <= '0;
            err_flag    <= 1'b0;
            arvalid_reg <= 1'b1;
            state       <= AR;
          end
        end
        AR: begin
          // addr_reg only changes in IDLE, so AR outputs hold while stalled.
          if (arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid) begin
            line_buf <= line_next;
            beat_cnt <= beat_cnt + 1'b1;
            err_flag <= err_flag | beat_err;
            if (beat_cnt == LAST_BEAT) begin
              line_reg   <= line_next;
              rready_reg <= 1'b0;
              rvalid_reg <= 1'b1;
              err_reg    <= err_flag | beat_err;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // rdy_o is masked by rst so nothing is accepted during the reset cycle,
  // yet the first cycle after release already accepts.
  assign rdy_o    = (state == IDLE) && !rst;
  assign rvalid_o = rvalid_reg;
  assign rdata_o  = line_reg;
  assign err_o    = err_reg;

  assign arvalid  = arvalid_reg;
  assign araddr   = addr_reg;
  assign arid     = AXI_ID;
  assign arlen    = 8'(NBEAT - 1);
  assign arsize   = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign arburst  = 2'b01;
  assign rready   = rready_reg;

endmodule

// File: tb/tb_axi_line_reader.sv
// tb_axi_line_reader
//   Directed bench for axi_line_reader with default parameters. The bench
//   plays the AXI slave cycle by cycle and checks every result against
//   hand-computed values. Expected err_o follows AXI_RRESP_CHECK_EN.
module tb_axi_line_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         rreq_i;
  logic [31:0]  addr_i;
  logic         rdy_o;
  logic         rvalid_o;
  logic [127:0] rdata_o;
  logic         err_o;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int pulse_cnt = 0;

`ifdef AXI_RRESP_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  axi_line_reader dut (
    .clk      (clk),
    .rst      (rst),
    .rreq_i   (rreq_i),
    .addr_i   (addr_i),
    .rdy_o    (rdy_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arvalid  (arvalid),
    .arready  (arready),
    .rid      (rid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready)
  );

  // Cycle counter plus AR handshake and rvalid_o pulse counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arvalid && arready) hs_cnt <= hs_cnt + 1;
    if (rvalid_o) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One full refill. Called right after a posedge (+#1). The slave answers
  // AR after ar_delay stall cycles and inserts gap idle cycles before each
  // beat; beat bad_beat (if >= 0) carries SLVERR.
  task automatic do_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [127:0] line, input logic [127:0] prev_line,
                         input int ar_delay, input int gap, input int bad_beat,
                         input logic hold, input logic exp_err, input int exp_lat);
    int t_acc;
    int hs0;
    int p0;
    hs0 = hs_cnt;
    p0  = pulse_cnt;
    rreq_i = 1'b1;
    addr_i = addr;
    @(negedge clk);
    check("rdy_idle", rdy_o, 1'b1);
    t_acc = cyc;
    @(posedge clk); #1;
    if (!hold) rreq_i = 1'b0;
    for (int i = 0; i < ar_delay; i++) begin
      arready = 1'b0;
      @(negedge clk);
      check("ar_stall_valid", arvalid, 1'b1);
      check("ar_stall_addr", araddr, exp_addr);
      check("rdy_busy", rdy_o, 1'b0);
      @(posedge clk); #1;
    end
    arready = 1'b1;
    @(negedge clk);
    check("arvalid", arvalid, 1'b1);
    check("araddr", araddr, exp_addr);
    check("arlen", arlen, 8'd3);
    check("arsize", arsize, 3'd2);
    check("arburst", arburst, 2'd1);
    check("arid", arid, 4'd0);
    check("rdata_hold", rdata_o, prev_line);
    @(posedge clk); #1;
    arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        @(negedge clk);
        check("rready_gap", rready, 1'b1);
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rdata  = line[k*32 +: 32];
      rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (k == 3);
      rid    = 4'd0;
      @(negedge clk);
      check("rready_beat", rready, 1'b1);
      check("no_early_valid", rvalid_o, 1'b0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rresp  = 2'b00;
    rlast  = 1'b0;
    @(negedge clk);
    check("rvalid_o", rvalid_o, 1'b1);
    check("rdata_o", rdata_o, line);
    check("err_o", err_o, exp_err);
    check("latency", 32'(cyc - t_acc), 32'(exp_lat));
    check("rdy_done", rdy_o, 1'b0);
    check("rready_done", rready, 1'b0);
    @(posedge clk); #1;
    rreq_i = 1'b0;
    @(negedge clk);
    check("rvalid_o_pulse_end", rvalid_o, 1'b0);
    check("err_o_idle", err_o, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("arvalid_idle", arvalid, 1'b0);
    check("hs_count", 32'(hs_cnt - hs0), 32'd1);
    check("pulse_count", 32'(pulse_cnt - p0), 32'd1);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
  localparam logic [127:0] LINE_C = 128'h0BAD0040_00C0FFEE_12345678_9ABCDEF0;
  localparam logic [127:0] LINE_D = 128'h5A5A5A5A_A5A5A5A5_F0F0F0F0_0F0F0F0F;

  initial begin
    int p0;
    rst = 1'b1; rreq_i = 1'b0; addr_i = '0; arready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", rdy_o, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_rvalid_o", rvalid_o, 1'b0);
    check("rst_err_o", err_o, 1'b0);
    check("rst_rdata_o", rdata_o, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Minimum latency line, requested in the first cycle out of reset.
    do_line(32'h1C00_0014, 32'h1C00_0010, LINE_A, 128'h0, 0, 0, -1, 1'b0, 1'b0, 6);
    // AR stalled 5 cycles, 2 idle cycles before each beat.
    do_line(32'h2000_0008, 32'h2000_0000, LINE_A, LINE_A, 5, 2, -1, 1'b0, 1'b0, 19);
    // Request held through the rvalid_o cycle.
    do_line(32'h0000_123F, 32'h0000_1230, LINE_B, LINE_A, 1, 0, -1, 1'b1, 1'b0, 7);

    // Reset after the second beat abandons the transaction.
    p0 = pulse_cnt;
    rreq_i = 1'b1; addr_i = 32'h0000_0080;
    @(posedge clk); #1;
    rreq_i = 1'b0; arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD0000;
    @(posedge clk); #1;
    rdata = 32'hDEAD0001;
    @(posedge clk); #1;
    rvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy", rdy_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_rdata_o", rdata_o, 128'h0);
    check("mid_rst_rdy_after", rdy_o, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    @(posedge clk); #1;
    do_line(32'h0000_0040, 32'h0000_0040, LINE_C, 128'h0, 0, 1, -1, 1'b0, 1'b0, 10);

    // Error response on beat 2, then a clean line.
    do_line(32'h3000_00F4, 32'h3000_00F0, LINE_D, LINE_C, 0, 0, 2, 1'b0, ERR_EN, 6);
    do_line(32'h3000_0100, 32'h3000_0100, LINE_B, LINE_D, 2, 0, -1, 1'b0, 1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
